cpu_mulx_sequencer: RTL and testbench

Multi-cycle sequencer that computes the full 64-bit product of two 32-bit operands for the CPU's extended multiply instructions (mulxuu, mulxsu, mulxss) and plain mul. It sits directly upstream of a shared 16x16 unsigned pipelined multiplier cell. It feeds that cell operand halves, consumes its 32-bit partial products, and accumulates them. It applies signed corrections and returns the selected 32-bit half to the execute stage.

---
 rtl/cpu_mulx_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_cpu_mulx_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mulx_sequencer.sv
// Sequencer for the 32x32->64 extended multiply. It issues four 16x16 partial
// products to a shared pipelined multiplier cell, accumulates them and applies signed fix-ups.
module cpu_mulx_sequencer #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        signed_a,
  input  logic        signed_b,
  input  logic        want_high,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [31:0] mul_p
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FIX   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e                       state_q, state_d;
  logic [31:0]                  a_q, a_d, b_q, b_d;
  logic                         sa_q, sa_d, sb_q, sb_d, wh_q, wh_d;
  logic [1:0]                   idx_q, idx_d;
  logic [63:0]                  acc_q, acc_d;
  logic [MUL_LATENCY-1:0]       tag_v_q, tag_v_d;
  logic [MUL_LATENCY-1:0][1:0]  tag_idx_q, tag_idx_d;
  logic                         busy_q, busy_d, done_q, done_d;
  logic [31:0]                  result_q, result_d;
  logic [15:0]                  mul_a_q, mul_a_d, mul_b_q, mul_b_d;

  logic                         push_v_s;
  logic                         tag_out_v_s;
  logic [1:0]                   tag_out_idx_s;
  logic [63:0]                  pp_shifted_s;
  logic [63:0]                  corr_a_s, corr_b_s;

  assign tag_out_v_s   = tag_v_q[MUL_LATENCY-1];
  assign tag_out_idx_s = tag_idx_q[MUL_LATENCY-1];

  // Align the returning partial product to its weight in the 64-bit accumulator
  always_comb begin
    pp_shifted_s = {32'd0, mul_p};
    case (tag_out_idx_s)
      2'd0:    pp_shifted_s = {32'd0, mul_p};
      2'd1:    pp_shifted_s = {16'd0, mul_p, 16'd0};
      2'd2:    pp_shifted_s = {16'd0, mul_p, 16'd0};
      2'd3:    pp_shifted_s = {mul_p, 32'd0};
      default: pp_shifted_s = {32'd0, mul_p};
    endcase
  end

  // Signed operands: subtract the other operand at weight 2^32 for each negative one
  always_comb begin
    corr_a_s = (sa_q && a_q[31]) ? {b_q, 32'd0} : 64'd0;
    corr_b_s = (sb_q && b_q[31]) ? {a_q, 32'd0} : 64'd0;
  end

  // Tag pipeline tracks which partial product the cell is returning
  always_comb begin
    tag_v_d      = tag_v_q;
    tag_idx_d    = tag_idx_q;
    tag_v_d[0]   = push_v_s;
    tag_idx_d[0] = idx_q;
    for (int i = 1; i < MUL_LATENCY; i++) begin
      tag_v_d[i]   = tag_v_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
  end

  // Next-state, accumulator and registered-output logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    wh_d     = wh_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    result_d = result_q;
    push_v_s = 1'b0;
    if (tag_out_v_s) begin
      acc_d = acc_q + pp_shifted_s;
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = src1;
          b_d     = src2;
          sa_d    = signed_a;
          sb_d    = signed_b;
          wh_d    = want_high;
          acc_d   = 64'd0;
          idx_d   = 2'd0;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        push_v_s = 1'b1;
        if (idx_q == 2'd3) begin
          idx_d   = 2'd0;
          state_d = ST_DRAIN;
        end else begin
          idx_d   = idx_q + 2'd1;
        end
      end
      ST_DRAIN: begin
        if (tag_out_v_s && (tag_out_idx_s == 2'd3)) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FIX: begin
        // result and done are registered so they both appear in the DONE cycle
        acc_d    = acc_q - corr_a_s - corr_b_s;
        result_d = wh_q ? acc_d[63:32] : acc_d[31:0];
        done_d   = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    if (state_d == ST_ISSUE) begin
      mul_a_d = idx_d[0] ? a_d[31:16] : a_d[15:0];
      mul_b_d = idx_d[1] ? b_d[31:16] : b_d[15:0];
    end else begin
      mul_a_d = 16'd0;
      mul_b_d = 16'd0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      wh_q      <= 1'b0;
      idx_q     <= 2'd0;
      acc_q     <= 64'd0;
      tag_v_q   <= '0;
      tag_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
      mul_a_q   <= 16'd0;
      mul_b_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      wh_q      <= wh_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      tag_v_q   <= tag_v_d;
      tag_idx_q <= tag_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;

endmodule

// File: tb/tb_cpu_mulx_sequencer.sv
// Bench for cpu_mulx_sequencer: two instances (latency 1 and 3) share stimulus;
// a product-level model checks every cycle, and directed vectors pin literal results.
module tb_cpu_mulx_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, start, signed_a, signed_b, want_high;
  logic [31:0] src1, src2;

  logic        busy_o   [2];
  logic        done_o   [2];
  logic [31:0] result_o [2];
  logic [15:0] mul_a_o  [2];
  logic [15:0] mul_b_o  [2];
  logic [31:0] mul_p_i  [2];

  logic [31:0] p1_pipe = 32'd0;
  logic [31:0] p3_pipe [3] = '{32'd0, 32'd0, 32'd0};

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  bit          m_act  [2];
  int          m_s    [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_b    [2];
  logic [31:0] m_res  [2];
  logic [63:0] m_prod [2];
  logic        m_wh   [2];

  always #5 clk = ~clk;

  cpu_mulx_sequencer #(.MUL_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .src1(src1), .src2(src2),
    .signed_a(signed_a), .signed_b(signed_b), .want_high(want_high),
    .busy(busy_o[0]), .done(done_o[0]), .result(result_o[0]),
    .mul_a(mul_a_o[0]), .mul_b(mul_b_o[0]), .mul_p(mul_p_i[0])
  );

  cpu_mulx_sequencer #(.MUL_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start), .src1(src1), .src2(src2),
    .signed_a(signed_a), .signed_b(signed_b), .want_high(want_high),
    .busy(busy_o[1]), .done(done_o[1]), .result(result_o[1]),
    .mul_a(mul_a_o[1]), .mul_b(mul_b_o[1]), .mul_p(mul_p_i[1])
  );

  // Multiplier cell models with latency 1 and 3
  always @(posedge clk) begin
    p1_pipe    <= {16'd0, mul_a_o[0]} * {16'd0, mul_b_o[0]};
    p3_pipe[0] <= {16'd0, mul_a_o[1]} * {16'd0, mul_b_o[1]};
    p3_pipe[1] <= p3_pipe[0];
    p3_pipe[2] <= p3_pipe[1];
  end
  assign mul_p_i[0] = p1_pipe;
  assign mul_p_i[1] = p3_pipe[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic sa, input logic sb);
    logic [63:0] ea, eb;
    ea = sa ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Cycle-level model: every cycle compares both instances against the product-level rules
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int k, lat, idx;
        logic eb, ed;
        logic [15:0] ea16, eb16;
        lat = (i == 0) ? 1 : 3;
        k = cyc - m_s[i];
        eb = 1'b0; ed = 1'b0; ea16 = 16'd0; eb16 = 16'd0;
        if (!reset_n) begin
          m_act[i] = 1'b0;
          m_res[i] = 32'd0;
        end else if (m_act[i]) begin
          eb = (k >= 1) && (k <= 6 + lat);
          ed = (k == 6 + lat);
          if (ed) m_res[i] = m_wh[i] ? m_prod[i][63:32] : m_prod[i][31:0];
          if (k >= 1 && k <= 4) begin
            idx = k - 1;
            ea16 = (idx % 2 == 1) ? m_a[i][31:16] : m_a[i][15:0];
            eb16 = (idx >= 2) ? m_b[i][31:16] : m_b[i][15:0];
          end
        end
        check($sformatf("busy[%0d]", i), 64'(busy_o[i]), 64'(eb));
        check($sformatf("done[%0d]", i), 64'(done_o[i]), 64'(ed));
        check($sformatf("result[%0d]", i), 64'(result_o[i]), 64'(m_res[i]));
        check($sformatf("mul_a[%0d]", i), 64'(mul_a_o[i]), 64'(ea16));
        check($sformatf("mul_b[%0d]", i), 64'(mul_b_o[i]), 64'(eb16));
        if (reset_n) begin
          if (m_act[i]) begin
            if (k == 6 + lat) m_act[i] = 1'b0;
          end else if (start) begin
            m_act[i]  = 1'b1;
            m_s[i]    = cyc;
            m_a[i]    = src1;
            m_b[i]    = src2;
            m_wh[i]   = want_high;
            m_prod[i] = ref_prod(src1, src2, signed_a, signed_b);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    src1 = $urandom; src2 = $urandom;
    signed_a = 1'($urandom); signed_b = 1'($urandom); want_high = 1'($urandom);
  endtask

  // One operation with literal expectations; poke adds ignored starts in cycles 3 and 7
  task automatic op(input string name, input logic [31:0] a, input logic [31:0] b,
                    input logic sa, input logic sb, input logic wh,
                    input logic [31:0] lit, input bit poke);
    logic [63:0] p;
    p = ref_prod(a, b, sa, sb);
    check({name, "_model"}, 64'(wh ? p[63:32] : p[31:0]), 64'(lit));
    src1 = a; src2 = b; signed_a = sa; signed_b = sb; want_high = wh; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      start = poke && (k == 3 || k == 7);
      scramble();
      if (k == 7) begin
        @(negedge clk);
        check({name, "_done1"}, 64'(done_o[0]), 64'd1);
        check({name, "_res1"}, 64'(result_o[0]), 64'(lit));
      end else if (k == 8) begin
        @(negedge clk);
        check({name, "_idle1"}, 64'(busy_o[0]), 64'd0);
      end else if (k == 9) begin
        @(negedge clk);
        check({name, "_done3"}, 64'(done_o[1]), 64'd1);
        check({name, "_busy3"}, 64'(busy_o[1]), 64'd1);
        check({name, "_res3"}, 64'(result_o[1]), 64'(lit));
      end else if (k == 10) begin
        @(negedge clk);
        check({name, "_idle3"}, 64'(busy_o[1]), 64'd0);
        check({name, "_nodone3"}, 64'(done_o[1]), 64'd0);
      end
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; src1 = 32'd0; src2 = 32'd0;
    signed_a = 1'b0; signed_b = 1'b0; want_high = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rst_busy", 64'(busy_o[0]), 64'd0);
    check("rst_result", 64'(result_o[1]), 64'd0);
    reset_n = 1'b1;
    step();
    step();

    op("uu_hi",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0);
    op("uu_lo",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h00000001, 1'b0);
    op("ss_hi",   32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0);
    op("ss_lo",   32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0);
    op("su_hi",   32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h80000000, 1'b0);
    op("su_lo",   32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h80000000, 1'b0);
    op("min_hi",  32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000, 1'b0);
    op("min_lo",  32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0);
    op("ignored", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b1);
    op("sweep",   32'h00012345, 32'h00010000, 1'b0, 1'b0, 1'b1, 32'h00000001, 1'b0);

    // Reset in cycle 4 of an operation: outputs drop at once and no done follows
    src1 = 32'h12345678; src2 = 32'h9ABCDEF0; signed_a = 1'b0; signed_b = 1'b0;
    want_high = 1'b1; start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      start = 1'b0;
      if (k == 4) begin
        reset_n = 1'b0;
        @(negedge clk);
        check("rstmid_busy1", 64'(busy_o[0]), 64'd0);
        check("rstmid_busy3", 64'(busy_o[1]), 64'd0);
        check("rstmid_mula1", 64'(mul_a_o[0]), 64'd0);
        check("rstmid_result1", 64'(result_o[0]), 64'd0);
      end else if (k == 6) begin
        reset_n = 1'b1;
      end
    end
    @(negedge clk);
    check("rstmid_final_result3", 64'(result_o[1]), 64'd0);
    check("rstmid_final_done1", 64'(done_o[0]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
